// File: rtl/booth_r4_seq_mult_ctrl.sv
// rtl/booth_r4_seq_mult_ctrl.sv - sequential radix-4 Booth multiplier driving an external W-bit adder
module booth_r4_seq_mult_ctrl #(
  parameter int N = 12,
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] mcand,
  input  logic [N-1:0] mplier,
  output logic         ready,
  output logic         busy,
  output logic [W-1:0] add_x,
  output logic [W-1:0] add_y,
  output logic         add_ci,
  input  logic [W-1:0] add_s,
  output logic [W-1:0] product,
  output logic         done
);

  localparam int D  = N / 2;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  m;
  logic [N:0]    q;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;

  logic          last_digit;
  logic [CW:0]   sh;
  logic [N:0]    q_sh;
  logic [2:0]    digit;
  logic          dig_pos;
  logic          dig_neg;
  logic          dig_dbl;
  logic [W-1:0]  m_ext;
  logic [W-1:0]  pp_base;
  logic [W-1:0]  pp;

  assign last_digit = (cnt == CW'(D - 1));
  assign ready      = (state == S_IDLE);
  assign busy       = (state == S_ADD);
  assign done       = (state == S_DONE);

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept start only when idle, walk N/2 digits, then one done cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ADD;
      S_ADD:   if (last_digit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, accumulator/digit counter update and product capture
  always_ff @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m   <= mcand;
            q   <= {mplier, 1'b0};
            acc <= '0;
            cnt <= '0;
          end
        end
        S_ADD: begin
          acc <= add_s;
          cnt <= cnt + 1'b1;
          if (last_digit) begin
            product <= add_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Booth digit recode and shifted, sign-extended partial product
  always_comb begin
    sh      = {cnt, 1'b0};
    q_sh    = q >> sh;
    digit   = q_sh[2:0];
    dig_pos = 1'b0;
    dig_neg = 1'b0;
    dig_dbl = 1'b0;
    case (digit)
      3'b001, 3'b010: dig_pos = 1'b1;
      3'b011: begin
        dig_pos = 1'b1;
        dig_dbl = 1'b1;
      end
      3'b100: begin
        dig_neg = 1'b1;
        dig_dbl = 1'b1;
      end
      3'b101, 3'b110: dig_neg = 1'b1;
      default: begin
      end
    endcase
    m_ext   = {{(W-N){m[N-1]}}, m};
    pp_base = dig_dbl ? (m_ext << 1) : m_ext;
    pp      = pp_base << sh;
  end

  // Adder operands: negation is ~P plus carry-in, so the adder does the subtract
  always_comb begin
    add_x  = '0;
    add_y  = '0;
    add_ci = 1'b0;
    if (state == S_ADD) begin
      add_x = acc;
      if (dig_neg) begin
        add_y  = ~pp;
        add_ci = 1'b1;
      end else if (dig_pos) begin
        add_y = pp;
      end
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult_ctrl.sv
// tb/tb_booth_r4_seq_mult_ctrl.sv - randomized self-checking bench for booth_r4_seq_mult_ctrl
module tb_booth_r4_seq_mult_ctrl;

  localparam int N = 12;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] mcand;
  logic [N-1:0] mplier;
  logic         ready;
  logic         busy;
  logic [W-1:0] add_x;
  logic [W-1:0] add_y;
  logic         add_ci;
  logic [W-1:0] add_s;
  logic [W-1:0] product;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  booth_r4_seq_mult_ctrl #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .ready  (ready),
    .busy   (busy),
    .add_x  (add_x),
    .add_y  (add_y),
    .add_ci (add_ci),
    .add_s  (add_s),
    .product(product),
    .done   (done)
  );

  // The external carry-ripple adder, modelled behaviourally
  assign add_s = add_x + add_y + W'(add_ci);

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!ready && k < budget) begin
      step();
      k++;
    end
    check_eq("wait_ready", {31'b0, ready}, 32'd1);
  endtask

  // Booth digit value of multiplier b at position i, from the radix-4 definition
  function automatic int digit_val(input logic [N-1:0] b, input int i);
    int lo;
    lo = 0;
    if (i > 0) lo = int'(b[2*i-1]);
    return -2 * int'(b[2*i+1]) + int'(b[2*i]) + lo;
  endfunction

  function automatic logic [W-1:0] ref_product(input logic [N-1:0] a, input logic [N-1:0] b);
    longint     p;
    logic [63:0] pv;
    p  = longint'($signed(a)) * longint'($signed(b));
    pv = p;
    return pv[W-1:0];
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    longint      acc_m;
    longint      term;
    logic [63:0] accv;
    logic [63:0] magv;
    logic [W-1:0] ey;
    int          dv;
    wait_ready(20);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    step();
    start  = 1'b0;
    acc_m  = 0;
    for (int i = 0; i < N/2; i++) begin
      dv   = digit_val(b, i);
      term = longint'(dv) * longint'($signed(a)) * (longint'(1) << (2*i));
      magv = (dv < 0) ? -term : term;
      accv = acc_m;
      if (dv == 0)     ey = '0;
      else if (dv > 0) ey = magv[W-1:0];
      else             ey = ~magv[W-1:0];
      check_eq("add_busy", {31'b0, busy}, 32'd1);
      check_eq("add_x", {8'b0, add_x}, {8'b0, accv[W-1:0]});
      check_eq("add_y", {8'b0, add_y}, {8'b0, ey});
      check_eq("add_ci", {31'b0, add_ci}, {31'b0, (dv < 0)});
      check_eq("add_nodone", {31'b0, done}, 32'd0);
      acc_m += term;
      step();
    end
    check_eq("done_pulse", {31'b0, done}, 32'd1);
    check_eq("product", {8'b0, product}, {8'b0, ref_product(a, b)});
    check_eq("done_ready", {31'b0, ready}, 32'd0);
    check_eq("done_x", {8'b0, add_x}, 32'd0);
    step();
    check_eq("after_done", {31'b0, done}, 32'd0);
    check_eq("after_ready", {31'b0, ready}, 32'd1);
  endtask

  initial begin
    int dpos0;
    int dpos1;
    int dcount;
    int seen_done;

    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    step();
    step();
    check_eq("rst_ready", {31'b0, ready}, 32'd1);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_product", {8'b0, product}, 32'd0);
    check_eq("rst_add", {7'b0, add_x | add_y, add_ci}, 32'd0);
    rst = 1'b0;
    step();

    // Directed cases
    run_op(12'd3, 12'd5);
    check_eq("t1_product", {8'b0, product}, 32'h00000F);
    run_op(12'h800, 12'h800);
    check_eq("t2_product", {8'b0, product}, 32'h400000);
    run_op(12'h800, 12'h7FF);
    check_eq("t3_product", {8'b0, product}, 32'hC00800);
    run_op(12'hFFF, 12'hFFF);
    check_eq("t4_product", {8'b0, product}, 32'h000001);

    // Start held high: back-to-back operations, done every 8 cycles
    wait_ready(20);
    mcand  = 12'h7FF;
    mplier = 12'h000;
    start  = 1'b1;
    dcount = 0;
    dpos0  = -1;
    dpos1  = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (busy) check_eq("t5_ci", {31'b0, add_ci}, 32'd0);
      if (done) begin
        if (dcount == 0) dpos0 = c;
        if (dcount == 1) dpos1 = c;
        dcount++;
        check_eq("t5_product", {8'b0, product}, 32'd0);
      end
    end
    start = 1'b0;
    check_eq("t5_dcount", dcount, 32'd2);
    check_eq("t5_dpos0", dpos0, 32'd7);
    check_eq("t5_dpos1", dpos1, 32'd15);
    wait_ready(20);

    // Reset in the middle of an operation
    mcand  = 12'd100;
    mplier = 12'hFF9;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    step();
    step();
    check_eq("t6_inadd", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t6_ready", {31'b0, ready}, 32'd1);
    check_eq("t6_busy", {31'b0, busy}, 32'd0);
    check_eq("t6_product", {8'b0, product}, 32'd0);
    check_eq("t6_add", {7'b0, add_x | add_y, add_ci}, 32'd0);
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) seen_done = 1;
      step();
    end
    check_eq("t6_nodone", seen_done, 32'd0);
    run_op(12'd100, 12'hFF9);
    check_eq("t6_product2", {8'b0, product}, 32'hFFFD44);

    // Randomized operands against the arithmetic reference
    for (int t = 0; t < 30; t++) begin
      run_op(N'($urandom_range(0, 4095)), N'($urandom_range(0, 4095)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_mult_ctrl.md
Name: booth_r4_seq_mult_ctrl

Overview:
- Sequential radix-4 Booth multiplier sequencer, directly upstream of the 24-bit carry-ripple adder stage.
- Per iteration it recodes one Booth digit of the multiplier and forms a shifted, sign-extended partial product.
- It drives the external adder's X/Y/Ci inputs (accumulator, partial product, negation carry) and registers the adder's sum back into the accumulator.
- After N/2 iterations it presents the signed 2N-bit product.

Parameters:
- N, 12, operand width in bits; must be even. Digit count is N/2 = 6.
- W, 24, accumulator/adder width; fixed at 2*N and must match the adder width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; sampled only when ready=1
- mcand  input  N  signed multiplicand; latched on accepted start
- mplier  input  N  signed multiplier; latched on accepted start
- ready  output  1  high only in IDLE
- busy  output  1  high in ADD
- add_x  output  W  to adder X: current accumulator
- add_y  output  W  to adder Y: partial product, or its bitwise inverse when negating
- add_ci  output  1  to adder Ci: 1 when negating
- add_s  input  W  from adder S; combinational in the same cycle; adder Co is unused
- product  output  W  signed product; held until overwritten
- done  output  1  one-cycle pulse when product updates

Behaviour:
- Reset, which takes priority over everything including mid-operation:
  - state=IDLE, acc=0, cnt=0, product=0, done=0, busy=0, ready=1.
  - add_x/add_y/add_ci=0. Any operation in flight is abandoned with no done pulse.
- States: IDLE -> ADD -> DONE -> IDLE.
- IDLE:
  - On start=1: latch M=mcand and Q={mplier,1'b0} (N+1 bits, appended q[-1]=0); set acc=0, cnt=0; go to ADD.
  - Outputs add_x/add_y/add_ci are 0 in IDLE.
- ADD (one digit per cycle, cnt=0..N/2-1):
  - Digit d = {Q[2cnt+2], Q[2cnt+1], Q[2cnt]}, i.e. {q[2i+1], q[2i], q[2i-1]}.
  - Recode: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - P = sign-extend M to W, doubled for ±2M, then shifted left by 2*cnt. Bits beyond W are discarded.
  - add_x = acc.
  - Positive digit: add_y = P, add_ci = 0.
  - Negative digit: add_y = ~P, add_ci = 1.
  - Zero digit: add_y = 0, add_ci = 0.
  - At the clock edge: acc <= add_s, cnt <= cnt+1.
  - When cnt = N/2-1: product <= add_s and state <= DONE.
- DONE:
  - done=1, ready=0, busy=0; add_* = 0; next state IDLE.
  - product keeps its value until the next completed operation.
- Latency: if start is sampled at edge E0, ADD occupies cycles 1..6 after E0 and done is high in cycle 7. The next start is accepted one cycle after done.
- start is ignored in ADD and DONE. It is not queued.
- Arithmetic is two's complement at W bits. No overflow is possible for N-bit signed inputs: the extreme case (-2^(N-1))^2 = 2^(2N-2) fits in W.
- All outputs are registered except add_x/add_y/add_ci. Those are combinational from state, cnt, acc, M and Q, so the whole adder ripple path fits in one cycle.

Test Plan:
1. mcand=3, mplier=5, start one cycle:
   - ADD cycle 0: add_y=0x000003, ci=0.
   - ADD cycle 1: add_y=0x00000C, ci=0.
   - ADD cycles 2..5: add_y=0, ci=0.
   - done in cycle 7; product=0x00000F.
2. mcand=-2048, mplier=-2048 -> product=0x400000.
3. mcand=-2048, mplier=2047 -> product=0xC00800.
4. mcand=-1, mplier=-1:
   - ADD cycle 0 (digit 110, -M): add_y=~0xFFFFFF=0x000000, ci=1.
   - All other digits are 0.
   - product=0x000001.
5. mcand=0x7FF, mplier=0; start held high for 20 cycles:
   - product=0; add_ci=0 in every ADD cycle.
   - Back-to-back operations with done every 8 cycles.
   - start asserted while busy has no effect.
6. mcand=100, mplier=-7; rst=1 in ADD cycle 3:
   - Next cycle: ready=1, product=0, add_*=0.
   - No done pulse.
   - A following start with 100 × -7 yields product=0xFFFD44 (-700).
